// File: rtl/pe_pkg.sv
// Shared definitions for the PE command sequencer: opcodes, shape widths, FSM states.
package pe_pkg;

    localparam int unsigned OP_W = 3;
    localparam int unsigned P_W  = 5;
    localparam int unsigned Q_W  = 3;
    localparam int unsigned S_W  = 4;

    localparam logic [OP_W-1:0] CMD_SET        = 3'b000;
    localparam logic [OP_W-1:0] CMD_LOAD_IFMAP = 3'b001;
    localparam logic [OP_W-1:0] CMD_LOAD_WGHT  = 3'b010;
    localparam logic [OP_W-1:0] CMD_CONV       = 3'b011;
    localparam logic [OP_W-1:0] CMD_ACC        = 3'b100;

    typedef enum logic [2:0] {
        StIdle,
        StIssSet,
        StIssLdw,
        StIssLdi,
        StIssConv,
        StIssAcc,
        StDrain
    } state_e;

    // Opcode presented while sitting in an issue state.
    function automatic logic [OP_W-1:0] state_opcode(input state_e st);
        logic [OP_W-1:0] op;
        op = CMD_SET;
        case (st)
            StIssSet:  op = CMD_SET;
            StIssLdw:  op = CMD_LOAD_WGHT;
            StIssLdi:  op = CMD_LOAD_IFMAP;
            StIssConv: op = CMD_CONV;
            StIssAcc:  op = CMD_ACC;
            default:   op = CMD_SET;
        endcase
        return op;
    endfunction

    function automatic logic is_issue_state(input state_e st);
        return (st == StIssSet) || (st == StIssLdw) || (st == StIssLdi) ||
               (st == StIssConv) || (st == StIssAcc);
    endfunction

endpackage

// File: rtl/pe_cmd_sequencer.sv
// Issues the per-layer command sequence to one PE over a valid/ready opcode channel.
module pe_cmd_sequencer
    import pe_pkg::*;
#(
    parameter int unsigned ROW_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [P_W-1:0]   i_layer_p,
    input  logic [Q_W-1:0]   i_layer_q,
    input  logic [S_W-1:0]   i_layer_s,
    input  logic [ROW_W-1:0] i_num_rows,
    input  logic             i_acc_en,
    input  logic             i_reuse_wght,
    input  logic             i_opcode_ready,
    output logic [OP_W-1:0]  o_opcode,
    output logic             o_opcode_valid,
    output logic [P_W-1:0]   o_layer_p,
    output logic [Q_W-1:0]   o_layer_q,
    output logic [S_W-1:0]   o_layer_s,
    output logic [ROW_W-1:0] o_row_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    state_e state_q, state_d;

    logic [P_W-1:0]   p_q, p_d;
    logic [Q_W-1:0]   q_q, q_d;
    logic [S_W-1:0]   s_q, s_d;
    logic [ROW_W-1:0] rows_q, rows_d;
    logic [ROW_W-1:0] row_idx_q, row_idx_d;
    logic             acc_en_q, acc_en_d;
    logic             reuse_q, reuse_d;

    logic             valid_q, valid_d;
    logic [OP_W-1:0]  opcode_q, opcode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic   hs;
    logic   shape_bad;
    logic   last_row;
    state_e loop_entry;

    assign hs         = valid_q && i_opcode_ready;
    assign shape_bad  = (i_layer_p == '0) || (i_layer_q == '0) || (i_layer_s == '0);
    assign last_row   = (row_idx_q == (rows_q - ROW_W'(1)));
    // A zero-row job skips the row loop entirely and only waits for the PE to settle.
    assign loop_entry = (rows_q != '0) ? StIssLdi : StDrain;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and job-context update; context only changes on accept or row advance.
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        q_d       = q_q;
        s_d       = s_q;
        rows_d    = rows_q;
        acc_en_d  = acc_en_q;
        reuse_d   = reuse_q;
        row_idx_d = row_idx_q;
        unique case (state_q)
            StIdle: begin
                if (i_start && !shape_bad) begin
                    p_d       = i_layer_p;
                    q_d       = i_layer_q;
                    s_d       = i_layer_s;
                    rows_d    = i_num_rows;
                    acc_en_d  = i_acc_en;
                    reuse_d   = i_reuse_wght;
                    row_idx_d = '0;
                    state_d   = StIssSet;
                end
            end
            StIssSet: begin
                if (hs) begin
                    state_d = reuse_q ? loop_entry : StIssLdw;
                end
            end
            StIssLdw: begin
                if (hs) begin
                    state_d = loop_entry;
                end
            end
            StIssLdi: begin
                if (hs) begin
                    state_d = StIssConv;
                end
            end
            StIssConv, StIssAcc: begin
                if (hs) begin
                    if ((state_q == StIssConv) && acc_en_q) begin
                        state_d = StIssAcc;
                    end else if (last_row) begin
                        state_d = StDrain;
                    end else begin
                        row_idx_d = row_idx_q + ROW_W'(1);
                        state_d   = StIssLdi;
                    end
                end
            end
            StDrain: begin
                if (i_opcode_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output next values, derived from where the FSM is heading so outputs stay registered.
    always_comb begin
        valid_d  = is_issue_state(state_d);
        opcode_d = valid_d ? state_opcode(state_d) : CMD_SET;
        busy_d   = (state_d != StIdle);
        done_d   = (state_q == StDrain) && (state_d == StIdle);
        err_d    = (state_q == StIdle) && i_start && shape_bad;
    end

    // Job-context registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            p_q       <= '0;
            q_q       <= '0;
            s_q       <= '0;
            rows_q    <= '0;
            acc_en_q  <= 1'b0;
            reuse_q   <= 1'b0;
            row_idx_q <= '0;
        end else begin
            p_q       <= p_d;
            q_q       <= q_d;
            s_q       <= s_d;
            rows_q    <= rows_d;
            acc_en_q  <= acc_en_d;
            reuse_q   <= reuse_d;
            row_idx_q <= row_idx_d;
        end
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign o_opcode       = opcode_q;
    assign o_opcode_valid = valid_q;
    assign o_layer_p      = p_q;
    assign o_layer_q      = q_q;
    assign o_layer_s      = s_q;
    assign o_row_idx      = row_idx_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_pe_cmd_sequencer.sv
// Self-checking bench for pe_cmd_sequencer: vector table, hand corner cases, random jobs.
module tb_pe_cmd_sequencer;
    import pe_pkg::*;

    localparam int unsigned ROW_W = 8;

    logic             clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic [P_W-1:0]   i_layer_p;
    logic [Q_W-1:0]   i_layer_q;
    logic [S_W-1:0]   i_layer_s;
    logic [ROW_W-1:0] i_num_rows;
    logic             i_acc_en;
    logic             i_reuse_wght;
    logic             i_opcode_ready;
    logic [OP_W-1:0]  o_opcode;
    logic             o_opcode_valid;
    logic [P_W-1:0]   o_layer_p;
    logic [Q_W-1:0]   o_layer_q;
    logic [S_W-1:0]   o_layer_s;
    logic [ROW_W-1:0] o_row_idx;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    pe_cmd_sequencer #(.ROW_W(ROW_W)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_layer_p      (i_layer_p),
        .i_layer_q      (i_layer_q),
        .i_layer_s      (i_layer_s),
        .i_num_rows     (i_num_rows),
        .i_acc_en       (i_acc_en),
        .i_reuse_wght   (i_reuse_wght),
        .i_opcode_ready (i_opcode_ready),
        .o_opcode       (o_opcode),
        .o_opcode_valid (o_opcode_valid),
        .o_layer_p      (o_layer_p),
        .o_layer_q      (o_layer_q),
        .o_layer_s      (o_layer_s),
        .o_row_idx      (o_row_idx),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;
        int row;
        int p;
        int q;
        int s;
    } hs_t;

    typedef struct {
        int p;
        int q;
        int s;
        int rows;
        int acc;
        int reuse;
        int lat;
        int exp_err;
        int exp_hs;
    } vec_t;

    int  checks = 0;
    int  errors = 0;
    hs_t hs_q[$];
    int  done_cnt, err_cnt, valid_cnt, busy_cnt;
    int  done_rdy_last, done_rdy_prev, rdy_prev;
    int  lat_cfg = 1;
    int  pe_cnt = 0;
    int  hold = 0;
    bit  scramble = 0;
    vec_t vecs[8];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock: record handshakes, check channel stability, advance the PE model.
    task automatic step();
        logic hs, vpre, rst_pre;
        int   rdy_before, pre_pack;
        hs_t  r;
        hs         = o_opcode_valid && i_opcode_ready;
        vpre       = o_opcode_valid;
        rst_pre    = i_rst;
        rdy_before = int'(i_opcode_ready);
        r.op = int'(o_opcode); r.row = int'(o_row_idx);
        r.p = int'(o_layer_p); r.q = int'(o_layer_q); r.s = int'(o_layer_s);
        pre_pack = int'({o_opcode_valid, o_opcode, o_layer_p, o_layer_q, o_layer_s, o_row_idx});
        @(posedge clk);
        #1;
        if (hs) begin
            hs_q.push_back(r);
        end else if (vpre && !rst_pre) begin
            check("hold_stable",
                  int'({o_opcode_valid, o_opcode, o_layer_p, o_layer_q, o_layer_s, o_row_idx}),
                  pre_pack);
        end
        if (o_done) begin
            done_cnt++;
            done_rdy_last = rdy_before;
            done_rdy_prev = rdy_prev;
        end
        if (o_err) err_cnt++;
        if (o_opcode_valid) valid_cnt++;
        if (o_busy) busy_cnt++;
        rdy_prev = rdy_before;
        i_start  = 1'b0;
        if (hs) pe_cnt = lat_cfg;
        else if (pe_cnt > 0) pe_cnt--;
        if (hold > 0) hold--;
        i_opcode_ready = (pe_cnt == 0) && (hold == 0);
        if (scramble && o_busy) begin
            i_layer_p    = P_W'($urandom);
            i_layer_q    = Q_W'($urandom);
            i_layer_s    = S_W'($urandom);
            i_num_rows   = ROW_W'($urandom);
            i_acc_en     = 1'($urandom);
            i_reuse_wght = 1'($urandom);
            i_start      = 1'($urandom);
        end
    endtask

    // Drive a job and compare everything the PE saw against the command list the job implies.
    task automatic run_job(input string name, input int p, input int q, input int s,
                           input int rows, input int acc, input int reuse, input int lat,
                           input int exp_hs, input int bp);
        hs_t exp_q[$];
        hs_t e;
        int  n, conv_seen;
        bit  bad, bp_done;
        bad = (p == 0) || (q == 0) || (s == 0);
        e.p = p; e.q = q; e.s = s; e.row = 0;
        if (!bad) begin
            e.op = int'(CMD_SET); exp_q.push_back(e);
            if (!reuse) begin e.op = int'(CMD_LOAD_WGHT); exp_q.push_back(e); end
            for (int r = 0; r < rows; r++) begin
                e.row = r;
                e.op = int'(CMD_LOAD_IFMAP); exp_q.push_back(e);
                e.op = int'(CMD_CONV);       exp_q.push_back(e);
                if (acc) begin e.op = int'(CMD_ACC); exp_q.push_back(e); end
            end
        end
        if (exp_hs >= 0) check({name, "_model_len"}, exp_q.size(), exp_hs);
        hs_q.delete();
        done_cnt = 0; err_cnt = 0; valid_cnt = 0; busy_cnt = 0;
        done_rdy_last = -1; done_rdy_prev = -1;
        lat_cfg = lat;
        i_layer_p = P_W'(p); i_layer_q = Q_W'(q); i_layer_s = S_W'(s);
        i_num_rows = ROW_W'(rows); i_acc_en = 1'(acc); i_reuse_wght = 1'(reuse);
        i_start = 1'b1;
        if (bad) begin
            step();
            check({name, "_err_first"}, int'(o_err), 1);
            repeat (5) step();
            check({name, "_err_cnt"}, err_cnt, 1);
            check({name, "_err_valid"}, valid_cnt, 0);
            check({name, "_err_busy"}, busy_cnt, 0);
            check({name, "_err_done"}, done_cnt, 0);
            return;
        end
        n = 0; bp_done = 0;
        while (done_cnt == 0 && n < 20000) begin
            step();
            n++;
            if (bp > 0 && !bp_done && o_opcode_valid && o_opcode == CMD_CONV) begin
                bp_done = 1;
                hold = bp;
                i_opcode_ready = 1'b0;
                for (int k = 0; k < bp; k++) begin
                    step();
                    check({name, "_bp_conv"}, int'({o_opcode_valid, o_opcode}), 4'b1011);
                end
                conv_seen = 0;
                foreach (hs_q[i]) if (hs_q[i].op == int'(CMD_CONV)) conv_seen++;
                check({name, "_bp_no_hs"}, conv_seen, 0);
            end
        end
        check({name, "_done_cnt"}, done_cnt, 1);
        check({name, "_hs_cnt"}, hs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
            if (hs_q[i].op != exp_q[i].op || hs_q[i].row != exp_q[i].row ||
                hs_q[i].p != exp_q[i].p || hs_q[i].q != exp_q[i].q || hs_q[i].s != exp_q[i].s)
                check($sformatf("%s_hs%0d_op_row", name, i),
                      hs_q[i].op * 1000 + hs_q[i].row, exp_q[i].op * 1000 + exp_q[i].row);
            else
                check($sformatf("%s_hs%0d", name, i), hs_q[i].op, exp_q[i].op);
        end
        check({name, "_done_after_ready"}, done_rdy_last * 10 + done_rdy_prev, 10);
        check({name, "_busy_end"}, int'({o_busy, o_opcode_valid}), 0);
    endtask

    initial begin
        vecs[0] = '{p: 4,  q: 3, s: 3,  rows: 2,   acc: 1, reuse: 0, lat: 5, exp_err: 0, exp_hs: 8};
        vecs[1] = '{p: 4,  q: 3, s: 3,  rows: 3,   acc: 0, reuse: 1, lat: 2, exp_err: 0, exp_hs: 7};
        vecs[2] = '{p: 7,  q: 1, s: 2,  rows: 0,   acc: 1, reuse: 0, lat: 3, exp_err: 0, exp_hs: 2};
        vecs[3] = '{p: 0,  q: 3, s: 3,  rows: 2,   acc: 1, reuse: 0, lat: 2, exp_err: 1, exp_hs: 0};
        vecs[4] = '{p: 4,  q: 0, s: 3,  rows: 2,   acc: 1, reuse: 0, lat: 2, exp_err: 1, exp_hs: 0};
        vecs[5] = '{p: 4,  q: 3, s: 0,  rows: 2,   acc: 1, reuse: 0, lat: 2, exp_err: 1, exp_hs: 0};
        vecs[6] = '{p: 31, q: 7, s: 15, rows: 255, acc: 0, reuse: 1, lat: 1, exp_err: 0, exp_hs: 511};
        vecs[7] = '{p: 1,  q: 1, s: 1,  rows: 1,   acc: 1, reuse: 1, lat: 1, exp_err: 0, exp_hs: 4};

        i_rst = 1'b1; i_start = 1'b0; i_opcode_ready = 1'b1;
        i_layer_p = '0; i_layer_q = '0; i_layer_s = '0;
        i_num_rows = '0; i_acc_en = 1'b0; i_reuse_wght = 1'b0;
        rdy_prev = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              int'({o_opcode, o_opcode_valid, o_layer_p, o_layer_q, o_layer_s, o_row_idx,
                    o_busy, o_done, o_err}), 0);
        i_rst = 1'b0;
        step();

        // Table vectors; consecutive normal jobs also exercise start-in-done-cycle.
        foreach (vecs[i]) begin
            run_job($sformatf("vec%0d", i), vecs[i].p, vecs[i].q, vecs[i].s, vecs[i].rows,
                    vecs[i].acc, vecs[i].reuse, vecs[i].lat,
                    vecs[i].exp_err ? 0 : vecs[i].exp_hs, 0);
        end

        // Backpressure: ready held low 20 cycles while CONV is presented.
        run_job("bp", 4, 3, 3, 2, 1, 0, 5, 8, 20);

        // Reset while CONV of row 1 is pending.
        lat_cfg = 3;
        i_layer_p = 5'd4; i_layer_q = 3'd3; i_layer_s = 4'd3; i_num_rows = 8'd3;
        i_acc_en = 1'b1; i_reuse_wght = 1'b0; i_start = 1'b1;
        begin
            int n = 0;
            step();
            while (!(o_opcode_valid && o_opcode == CMD_CONV && o_row_idx == 8'd1) && n < 500) begin
                step();
                n++;
            end
            check("rst_reached_conv", int'({o_opcode_valid, o_opcode, o_row_idx}), 12'h301 | 12'h800);
        end
        i_rst = 1'b1;
        step();
        check("rst_mid_job", int'({o_opcode_valid, o_busy, o_row_idx}), 0);
        i_rst = 1'b0; pe_cnt = 0; hold = 0; i_opcode_ready = 1'b1;
        valid_cnt = 0;
        repeat (5) step();
        check("rst_no_cmds", valid_cnt, 0);
        run_job("after_rst", 4, 3, 3, 1, 0, 0, 2, 4, 0);

        // Random jobs with shape inputs and start scrambled while busy.
        scramble = 1;
        for (int j = 0; j < 25; j++) begin
            int rp, rq, rs;
            rp = (j % 7 == 3) ? 0 : int'($urandom_range(1, 31));
            rq = int'($urandom_range(1, 7));
            rs = int'($urandom_range(1, 15));
            run_job($sformatf("rnd%0d", j), rp, rq, rs, int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(1, 4)), -1, 0);
        end
        scramble = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_cmd_sequencer.md
Name: pe_cmd_sequencer

Overview:
- Command initiator for one PE control unit: drives the opcode valid/ready channel and holds the layer-shape bus stable.
- Takes a per-layer job descriptor from the global controller and issues the fixed command sequence: SET, LOAD_WGHT, then per ifmap row LOAD_IFMAP, CONV and optional ACC.
- Waits for the PE to return to idle after the last command, then pulses done.

Parameters:
- ROW_W, 8, width of row-count input and row index.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  job start pulse; sampled only when o_busy=0
- i_layer_p  in  5  filters per PE (P)
- i_layer_q  in  3  channels per PE (Q)
- i_layer_s  in  4  filter row width (S)
- i_num_rows  in  ROW_W  ifmap rows to process
- i_acc_en  in  1  issue ACC after each CONV
- i_reuse_wght  in  1  skip LOAD_WGHT (weights already resident)
- i_opcode_ready  in  1  PE ready, high only while PE is idle
- o_opcode  out  3  command code
- o_opcode_valid  out  1  command valid
- o_layer_p  out  5  registered P, held for whole job
- o_layer_q  out  3  registered Q
- o_layer_s  out  4  registered S
- o_row_idx  out  ROW_W  current row index
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  one-cycle pulse: job rejected

Behaviour:
- Reset values: every output is 0 and the state is IDLE. A reset mid-job drops valid on the same edge and issues no further commands.
- Opcodes: SET=000, LOAD_IFMAP=001, LOAD_WGHT=010, CONV=011, ACC=100.
- Handshake: hs = o_opcode_valid && i_opcode_ready at a rising edge.
  - While valid=1, o_opcode and o_layer_* are stable until hs.
  - Valid never drops without hs.
  - All outputs are registered.
- States: IDLE, ISS_SET, ISS_LDW, ISS_LDI, ISS_CONV, ISS_ACC, DRAIN.
  - Valid=1 in every ISS_* state.
  - o_opcode is the code for the current state.
- IDLE, on i_start:
  - If P, Q or S is 0: o_err=1 for one cycle and stay in IDLE.
  - Otherwise: latch P, Q, S, rows, acc_en and reuse_wght; set o_row_idx=0, o_busy=1, state ISS_SET.
  - Valid appears one cycle after i_start.
- Transitions on hs:
  - ISS_SET goes to ISS_LDW if reuse_wght=0, else to row loop entry.
  - ISS_LDW goes to row loop entry.
  - Row loop entry goes to ISS_LDI if rows>0, else to DRAIN.
  - ISS_LDI goes to ISS_CONV.
  - ISS_CONV goes to ISS_ACC if acc_en, else to row end.
  - ISS_ACC goes to row end.
  - Row end: if row_idx == rows-1, go to DRAIN; else increment row_idx and go to ISS_LDI.
- DRAIN:
  - Valid=0.
  - When i_opcode_ready=1, go to IDLE with o_busy=0 and o_done=1 for one cycle.
  - The PE's ready is low from the cycle after hs, so DRAIN cannot end early.
- i_start while busy is ignored.
- i_start in the same cycle as o_done is accepted.
- Shape inputs are ignored except when a job is accepted.
- Rows wrap: row_idx never exceeds rows-1. rows = 2^ROW_W - 1 is legal.
- Back-to-back issue: the next command is presented with valid=1 on the cycle after hs.

Decomposition:
- Shared package pe_pkg holds:
  - opcode localparams (CMD_SET … CMD_ACC);
  - shape widths (P_W=5, Q_W=3, S_W=4).
- Single module; no sub-module needed.

Test Plan:
- P=4, Q=3, S=3, rows=2, acc_en=1, reuse=0; PE model holds ready low 5 cycles per command. Expected:
  - 8 handshakes in order SET, LOAD_WGHT, LOAD_IFMAP, CONV, ACC, LOAD_IFMAP, CONV, ACC;
  - o_layer_* = 4/3/3 throughout;
  - o_done exactly one cycle after the model's ready returns.
- reuse_wght=1, acc_en=0, rows=3: SET, then (LOAD_IFMAP, CONV)×3; no LOAD_WGHT or ACC; row_idx steps 0, 1, 2.
- rows=0: SET and LOAD_WGHT only, then DRAIN, then o_done.
- P=0 start: o_err pulses one cycle; o_busy stays 0; no valid ever asserted.
- Backpressure: ready held 0 for 20 cycles mid-CONV. Expected: valid stays 1 and opcode stays 011 throughout; exactly one hs when ready rises.
- i_rst asserted while in ISS_CONV: next cycle valid=0, busy=0, row_idx=0; a new i_start then restarts from SET.
